gate_bist_controller: RTL and testbench

//  Built-in self-test driver for the combinational gate models in the simulator gate library
//    (18 inputs, 10 outputs).

---
 rtl/gate_bist_pkg.sv | 17 +
 rtl/bist_misr.sv | 25 ++
 rtl/gate_bist_controller.sv | 100 ++++++++++
 tb/tb_gate_bist_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-model BIST controller.
// The LFSR and MISR taps are fixed for the 18-in/10-out gate library footprint.
package gate_bist_pkg;

  localparam int DEF_IN_W  = 18;
  localparam int DEF_OUT_W = 10;
  localparam int DEF_CNT_W = 16;

  // x^18 + x^11 + 1 and x^10 + x^7 + 1, expressed as register bit taps.
  localparam int LFSR_TAP_HI = 17;
  localparam int LFSR_TAP_LO = 10;
  localparam int MISR_TAP_HI = 9;
  localparam int MISR_TAP_LO = 6;

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register that compacts the gate model's response.
// A clear takes priority over an update so that a run always starts from zero.
module bist_misr
  import gate_bist_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [OUT_W-1:0] data,
  output logic [OUT_W-1:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sig <= '0;
    else if (clear)
      sig <= '0;
    else if (enable)
      sig <= {sig[OUT_W-2:0], sig[MISR_TAP_HI] ^ sig[MISR_TAP_LO]} ^ data;
  end

endmodule

// File: rtl/gate_bist_controller.sv
// BIST driver for one combinational gate model: LFSR stimulus, MISR compaction
// and a golden-signature compare, started and observed by the lab controller.
module gate_bist_controller
  import gate_bist_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  seed,
  input  logic [CNT_W-1:0] pat_count,
  input  logic [OUT_W-1:0] golden,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] signature,
  output logic             pass
);

  state_t           state, next_state;
  logic [IN_W-1:0]  lfsr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pat_cnt_q;
  logic [OUT_W-1:0] golden_q;
  logic             last_pat;
  logic             load;
  logic             step;
  logic             misr_clr;

  assign last_pat = (cnt == pat_cnt_q - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort)
      next_state = IDLE;
    else begin
      case (state)
        IDLE:    if (start) next_state = INIT;
        INIT:    next_state = (pat_count == '0) ? DONE : RUN;
        RUN:     if (last_pat) next_state = DONE;
        DONE:    if (start) next_state = INIT;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state == INIT) || (state == RUN);
    done     = (state == DONE);
    load     = (state == INIT) && !abort;
    step     = (state == RUN) && !abort;
    misr_clr = (state == INIT) || abort;
  end

  // The LFSR holds on the final update so dut_in keeps the last applied pattern in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= '0;
      cnt       <= '0;
      pat_cnt_q <= '0;
      golden_q  <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (load) begin
      lfsr      <= (seed == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : seed;
      cnt       <= '0;
      pat_cnt_q <= pat_count;
      golden_q  <= golden;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (!last_pat)
        lfsr <= {lfsr[IN_W-2:0], lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO]};
    end
  end

  bist_misr #(.OUT_W(OUT_W)) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (misr_clr),
    .enable (step),
    .data   (dut_out),
    .sig    (signature)
  );

  assign dut_in = lfsr;
  assign pass   = done && (signature == golden_q);

endmodule

// File: tb/tb_gate_bist_controller.sv
// Directed bench for gate_bist_controller with a small 18-in/10-out gate model
// and an independent LFSR/MISR reference for the long run.
module tb_gate_bist_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [17:0] seed = '0;
  logic [15:0] pat_count = '0;
  logic [9:0]  golden = '0;
  logic [17:0] dut_in;
  logic [9:0]  dut_out;
  logic        busy;
  logic        done;
  logic [9:0]  signature;
  logic        pass;

  logic        use_model = 1'b0;
  logic [9:0]  out_const = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;

  always #5 clk = ~clk;

  function automatic logic [9:0] gate_model(input logic [17:0] x);
    logic [9:0] y;
    for (int j = 0; j < 10; j++)
      y[j] = (x[j] ^ x[j+8]) | (x[(j+3)%18] & ~x[17-j]);
    return y;
  endfunction

  assign dut_out = use_model ? gate_model(dut_in) : out_const;

  gate_bist_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .pat_count (pat_count),
    .golden    (golden),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .signature (signature),
    .pass      (pass)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference signature straight from the polynomial definitions.
  function automatic logic [9:0] ref_sig(input logic [17:0] s, input int n,
                                         input bit model, input logic [9:0] c);
    logic [17:0] l;
    logic [9:0]  m;
    logic [9:0]  r;
    l = (s == 18'd0) ? 18'd1 : s;
    m = '0;
    for (int i = 0; i < n; i++) begin
      r = model ? gate_model(l) : c;
      m = {m[8:0], m[9] ^ m[6]} ^ r;
      l = {l[16:0], l[17] ^ l[10]};
    end
    return m;
  endfunction

  // Pulse start, then count cycles until done (bounded); lat includes the start cycle.
  task automatic run_bist(input logic [17:0] s, input logic [15:0] pc,
                          input logic [9:0] g, output int latency);
    seed = s; pat_count = pc; golden = g;
    start = 1'b1;
    tick();
    start = 1'b0;
    latency = 1;
    while (!done && latency < 2000) begin
      tick();
      latency++;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_dut_in", 32'(dut_in), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_sig", 32'(signature), 32'h0);
    check("rst_pass", 32'(pass), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Walking-one stimulus with zero response.
    seed = 18'h1; pat_count = 16'd5; golden = '0; out_const = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("init_busy", 32'(busy), 32'h1);
    check("init_done", 32'(done), 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("walk_dut_in", 32'(dut_in), 32'(18'h1 << i));
      check("walk_busy", 32'(busy), 32'h1);
      check("walk_not_done", 32'(done), 32'h0);
      tick();
    end
    check("walk_done", 32'(done), 32'h1);
    check("walk_sig", 32'(signature), 32'h0);
    check("walk_hold", 32'(dut_in), 32'h10);
    check("walk_pass", 32'(pass), 32'h1);
    tick();
    check("walk_hold2", 32'(dut_in), 32'h10);

    // Constant response 0x001 over two patterns.
    out_const = 10'h001;
    run_bist(18'h1, 16'd2, 10'h003, lat);
    check("c1_lat", 32'(lat), 32'd4);
    check("c1_sig", 32'(signature), 32'h003);
    check("c1_pass", 32'(pass), 32'h1);
    run_bist(18'h1, 16'd2, 10'h002, lat);
    check("c1_sig_again", 32'(signature), 32'h003);
    check("c1_fail_pass", 32'(pass), 32'h0);

    // Zero seed is replaced by one.
    out_const = '0;
    seed = '0; pat_count = 16'd1; golden = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("seed0_dut_in", 32'(dut_in), 32'h1);
    check("seed0_busy", 32'(busy), 32'h1);
    tick();
    check("seed0_done", 32'(done), 32'h1);
    check("seed0_hold", 32'(dut_in), 32'h1);

    // Empty run.
    out_const = 10'h155;
    run_bist(18'h3, 16'd0, 10'h000, lat);
    check("p0_lat", 32'(lat), 32'd2);
    check("p0_sig", 32'(signature), 32'h0);
    check("p0_pass", 32'(pass), 32'h1);

    // Abort on the third RUN cycle, then a clean restart.
    out_const = 10'h001;
    seed = 18'h1; pat_count = 16'd10; golden = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("ab_sig_partial", 32'(signature), 32'h003);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'h0);
    check("ab_done", 32'(done), 32'h0);
    check("ab_sig", 32'(signature), 32'h0);
    run_bist(18'h1, 16'd2, 10'h003, lat);
    check("ab_restart_lat", 32'(lat), 32'd4);
    check("ab_restart_sig", 32'(signature), 32'h003);
    check("ab_restart_pass", 32'(pass), 32'h1);

    // Abort wins over start in DONE.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abst_busy", 32'(busy), 32'h0);
    check("abst_done", 32'(done), 32'h0);
    tick();
    check("abst_idle", 32'(busy), 32'h0);

    // Asynchronous reset in the middle of a run.
    seed = 18'h1; pat_count = 16'd10; golden = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("ar_dut_in", 32'(dut_in), 32'h0);
    check("ar_sig", 32'(signature), 32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_done", 32'(done), 32'h0);
    check("ar_pass", 32'(pass), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Start pulsed while busy is ignored.
    seed = 18'h1; pat_count = 16'd6; golden = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    repeat (2) begin tick(); lat++; end
    start = 1'b1;
    tick();
    lat++;
    start = 1'b0;
    while (!done && lat < 100) begin tick(); lat++; end
    check("ign_lat", 32'(lat), 32'd8);
    check("ign_sig", 32'(signature), 32'(ref_sig(18'h1, 6, 1'b0, 10'h001)));

    // Long run through the gate model against the reference.
    use_model = 1'b1;
    run_bist(18'h2A5F3, 16'd500, ref_sig(18'h2A5F3, 500, 1'b1, 10'h0), lat);
    check("gm_lat", 32'(lat), 32'd502);
    check("gm_sig", 32'(signature), 32'(ref_sig(18'h2A5F3, 500, 1'b1, 10'h0)));
    check("gm_pass", 32'(pass), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
